// File: rtl/alu_exec_unit.sv
// Sequential ALU execute unit for the multicycle CPU EX stage.
// Decodes ALUOp/Opcode, runs single-cycle ops in one step, and iterates MUL and SLL one bit per cycle.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Flush,
  input  logic [5:0]       Opcode,
  input  logic [1:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [2:0]       ALUCTLline,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b011;
  localparam logic [2:0] CTL_XOR = 3'b100;
  localparam logic [2:0] CTL_SLT = 3'b101;
  localparam logic [2:0] CTL_MUL = 3'b110;
  localparam logic [2:0] CTL_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        ctl;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [CNTW-1:0]   cnt;

  logic              accept;
  logic [2:0]        dec;
  logic [SHW-1:0]    shamt;
  logic              iterative;
  logic [WIDTH-1:0]  sc_result;
  logic              sc_ovf;
  logic [WIDTH-1:0]  b_neg;
  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  diff;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]  step_next;
  logic              last_step;

  // Opcode bits above [2:0] carry no meaning for the ALU.
  logic unused_opcode;
  assign unused_opcode = ^Opcode[5:3];

  function automatic logic [2:0] decode(input logic [1:0] aluop, input logic [2:0] opc);
    logic [2:0] c;
    case (aluop)
      2'b00:   c = CTL_ADD;
      2'b01:   c = (opc == 3'b011 || opc == 3'b100) ? CTL_SLT : CTL_XOR;
      2'b10:   c = CTL_SUB;
      default: c = opc;
    endcase
    return c;
  endfunction

  // Signed overflow of x + y = s: operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign accept    = (state == IDLE) && Start && !Flush;
  assign dec       = decode(ALUOp, Opcode[2:0]);
  assign shamt     = B[SHW-1:0];
  assign iterative = (dec == CTL_MUL) || ((dec == CTL_SLL) && (shamt != '0));
  assign last_step = (cnt == CNTW'(1));
  assign Busy      = (state != IDLE);

  assign a_s   = A;
  assign b_s   = B;
  assign b_neg = ~B + WIDTH'(1);
  assign sum   = A + B;
  assign diff  = A + b_neg;

  always_comb begin
    sc_result = A;
    sc_ovf    = 1'b0;
    case (dec)
      CTL_AND: sc_result = A & B;
      CTL_OR:  sc_result = A | B;
      CTL_ADD: begin
        sc_result = sum;
        sc_ovf    = add_ovf(A, B, sum);
      end
      CTL_SUB: begin
        sc_result = diff;
        sc_ovf    = add_ovf(A, b_neg, diff);
      end
      CTL_XOR: sc_result = A ^ B;
      CTL_SLT: sc_result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: sc_result = A;
    endcase
  end

  // One iteration: shift-add multiply step or a single-bit left shift.
  always_comb begin
    step_next = acc << 1;
    if (ctl == CTL_MUL) begin
      step_next = acc + (opb[0] ? opa : '0);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = iterative ? ITER : DONE;
        end
      end
      ITER: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (Flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      ctl        <= '0;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      cnt        <= '0;
      ALUCTLline <= '0;
      Done       <= 1'b0;
      Result     <= '0;
      Zero       <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      state <= state_next;
      Done  <= (state == DONE) && !Flush;
      if (accept) begin
        ctl <= dec;
        opa <= A;
        opb <= B;
        if (dec == CTL_MUL) begin
          acc <= '0;
          cnt <= CNTW'(WIDTH);
        end else begin
          acc <= A;
          cnt <= {1'b0, shamt};
        end
        if (!iterative) begin
          Result     <= sc_result;
          Zero       <= (sc_result == '0);
          Overflow   <= sc_ovf;
          ALUCTLline <= dec;
        end
      end else if (state == ITER && !Flush) begin
        acc <= step_next;
        opa <= opa << 1;
        opb <= opb >> 1;
        cnt <= cnt - CNTW'(1);
        if (last_step) begin
          Result     <= step_next;
          Zero       <= (step_next == '0);
          Overflow   <= 1'b0;
          ALUCTLline <= ctl;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic [5:0]   opcode;
  logic [1:0]   aluop;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   aluctl;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] last_r;
  logic         last_z;
  logic         last_ovf;
  logic [2:0]   last_ctl;

  alu_exec_unit #(.WIDTH(W)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Flush(flush), .Opcode(opcode), .ALUOp(aluop),
    .A(a), .B(b), .ALUCTLline(aluctl), .Busy(busy), .Done(done), .Result(result),
    .Zero(zero), .Overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: control code, result, overflow and Done latency from plain arithmetic.
  function automatic void model(input logic [1:0] op, input logic [5:0] opc,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [2:0] c, output logic [W-1:0] r,
                                output logic v, output int lat);
    longint s;
    logic [W-1:0] yn;
    if (op == 2'b00) c = 3'b010;
    else if (op == 2'b10) c = 3'b011;
    else if (op == 2'b01) c = (opc[2:0] == 3'd3 || opc[2:0] == 3'd4) ? 3'b101 : 3'b100;
    else c = opc[2:0];
    v   = 1'b0;
    lat = 1;
    yn  = -y;
    case (c)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin
        r = x + y;
        s = longint'($signed(x)) + longint'($signed(y));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: begin
        r = x - y;
        s = longint'($signed(x)) + longint'($signed(yn));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd4: r = x ^ y;
      3'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd6: begin
        r   = x * y;
        lat = W + 1;
      end
      default: begin
        r   = x << y[4:0];
        lat = (y[4:0] == 0) ? 1 : int'(y[4:0]) + 1;
      end
    endcase
  endfunction

  // Issue one op at a negedge; optionally pulse Start again at iteration 'poke'.
  task automatic run_op(input logic [1:0] op, input logic [5:0] opc, input logic [W-1:0] x,
                        input logic [W-1:0] y, input string tag, input int poke);
    logic [2:0]   ec;
    logic [W-1:0] er;
    logic         ev;
    int           el;
    int           lat;
    logic         seen;
    model(op, opc, x, y, ec, er, ev, el);
    aluop = op; opcode = opc; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      start = (poke != 0) && (lat == poke);
      if (start) begin
        aluop = 2'b00; a = 32'd1; b = 32'd1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, lat, el);
    check({tag, "_result"}, result, er);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (er == 0)});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ev});
    check({tag, "_ctl"}, {29'd0, aluctl}, {29'd0, ec});
    last_r = er; last_z = (er == 0); last_ovf = ev; last_ctl = ec;
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt_done;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; opcode = '0; aluop = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, zero, overflow, 1'b0}, 32'd0);
    check("rst_ctl", {29'd0, aluctl}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 6'd0, 32'd5, 32'd7, "add_5_7", 0);
    run_op(2'b10, 6'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "sub_zero", 0);
    run_op(2'b10, 6'd0, 32'h8000_0000, 32'd1, "sub_ovf", 0);
    run_op(2'b10, 6'd0, 32'hFFFF_FFFF, 32'h8000_0000, "sub_minneg", 0);
    run_op(2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1, "add_ovf", 0);
    run_op(2'b01, 6'd3, 32'hFFFF_FFFE, 32'd1, "slt_neg", 0);
    run_op(2'b01, 6'd4, 32'd9, 32'd2, "slt_pos", 0);
    run_op(2'b01, 6'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, "xor", 0);
    run_op(2'b11, 6'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, "and", 0);
    run_op(2'b11, 6'd1, 32'hF0F0_F0F0, 32'h0F00_0F00, "or", 0);
    run_op(2'b11, 6'd6, 32'd3, 32'hFFFF_FFFF, "mul_3_m1", 0);
    run_op(2'b11, 6'd7, 32'h1234_5678, 32'd0, "sll_0", 0);
    run_op(2'b11, 6'd7, 32'd1, 32'd31, "sll_31", 0);
    run_op(2'b11, 6'd6, 32'd7, 32'd9, "mul_poke", 3);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 6'($urandom), $urandom, $urandom, "rand", 0);
    end

    // Flush during MUL iteration: no Done, outputs hold.
    aluop = 2'b11; opcode = 6'd6; a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {31'd0, busy}, 32'd0);
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("flush_no_done", cnt_done, 0);
    check("flush_result", result, last_r);
    check("flush_flags", {30'd0, zero, overflow}, {30'd0, last_z, last_ovf});
    check("flush_ctl", {29'd0, aluctl}, {29'd0, last_ctl});

    // Flush and Start together in IDLE: not accepted.
    aluop = 2'b00; a = 32'd1; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    cnt_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("flush_start_no_done", cnt_done, 0);

    // Asynchronous reset in the middle of a MUL.
    aluop = 2'b11; opcode = 6'd6; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b00, 6'd0, 32'd100, 32'd23, "add_after_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
